// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 arbiter that locks the grant for a whole packet and feeds a
// single registered output slot. It also counts completed packets per source.
module mux2_rr_arbiter #(
    parameter int WIDTH = 100,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel,
    output logic [CNT_W-1:0] pkt_cnt_a,
    output logic [CNT_W-1:0] pkt_cnt_b
);

    localparam int N = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   prio_q, prio_d;
    logic   sel_q, sel_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic             out_src_q;

    logic             load;
    logic             grant_a, grant_b;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;

    logic [N-1:0]     valid_vec, last_vec, ready_vec, xfer_vec, done_vec;
    logic [CNT_W-1:0] cnt_q [N];

    assign load = ~out_valid_q | out_ready;

    // Grant and select depend only on valids, state and prio, never on data.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                grant_a = a_valid & (~b_valid | ~prio_q);
                grant_b = b_valid & (~a_valid | prio_q);
                if (grant_b) begin
                    sel_d = 1'b1;
                end else if (grant_a) begin
                    sel_d = 1'b0;
                end
            end
            LOCK_A: begin
                grant_a = 1'b1;
                sel_d   = 1'b0;
            end
            LOCK_B: begin
                grant_b = 1'b1;
                sel_d   = 1'b1;
            end
            default: begin
                sel_d = 1'b0;
            end
        endcase
    end

    assign a_ready = ~rst & load & grant_a;
    assign b_ready = ~rst & load & grant_b;
    assign sel     = sel_d;

    assign valid_vec = {b_valid, a_valid};
    assign last_vec  = {b_last, a_last};
    assign ready_vec = {b_ready, a_ready};
    assign xfer_vec  = valid_vec & ready_vec;
    assign done_vec  = xfer_vec & last_vec;

    assign mux_data = sel_d ? b_data : a_data;
    assign mux_last = sel_d ? b_last : a_last;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (xfer_vec[0] && !a_last) begin
                    state_d = LOCK_A;
                end else if (xfer_vec[1] && !b_last) begin
                    state_d = LOCK_B;
                end
            end
            LOCK_A: begin
                if (done_vec[0]) begin
                    state_d = IDLE;
                end
            end
            LOCK_B: begin
                if (done_vec[1]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A finished packet hands preference to the other requester.
        if (done_vec[0]) begin
            prio_d = 1'b1;
        end else if (done_vec[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    // A new transfer always wins over a drain, so drain+refill keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else if (|xfer_vec) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_last_q  <= mux_last;
            out_src_q   <= sel_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q[gi] <= '0;
                end else if (done_vec[gi]) begin
                    cnt_q[gi] <= cnt_q[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign pkt_cnt_a = cnt_q[0];
    assign pkt_cnt_b = cnt_q[1];

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a vector table walked cycle by cycle,
// then hand sequences for alternation, reset inside a lock and counter wrap.
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 100;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, a_last, a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid, b_last, b_ready;
    logic [WIDTH-1:0] b_data;
    logic             out_valid, out_last, out_src, out_ready, sel;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] pkt_cnt_a, pkt_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel),
        .pkt_cnt_a (pkt_cnt_a),
        .pkt_cnt_b (pkt_cnt_b)
    );

    typedef struct {
        logic             rst, av;
        logic [WIDTH-1:0] ad;
        logic             al, bv;
        logic [WIDTH-1:0] bd;
        logic             bl, ordy;
        logic             ear, ebr, esel, eov;
        logic [WIDTH-1:0] eod;
        logic             eol, eos;
        logic [CNT_W-1:0] eca, ecb;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic r, input logic av, input logic [WIDTH-1:0] ad, input logic al,
        input logic bv, input logic [WIDTH-1:0] bd, input logic bl, input logic ordy,
        input logic ear, input logic ebr, input logic esel,
        input logic eov, input logic [WIDTH-1:0] eod, input logic eol, input logic eos,
        input logic [CNT_W-1:0] eca, input logic [CNT_W-1:0] ecb);
        vec_t v;
        v.rst = r;   v.av = av;   v.ad = ad;   v.al = al;
        v.bv = bv;   v.bd = bd;   v.bl = bl;   v.ordy = ordy;
        v.ear = ear; v.ebr = ebr; v.esel = esel;
        v.eov = eov; v.eod = eod; v.eol = eol; v.eos = eos;
        v.eca = eca; v.ecb = ecb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [WIDTH-1:0] ad,
                         input logic al, input logic bv, input logic [WIDTH-1:0] bd,
                         input logic bl, input logic ordy);
        @(negedge clk);
        rst = r;  a_valid = av; a_data = ad; a_last = al;
        b_valid = bv; b_data = bd; b_last = bl; out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0; out_ready = 1'b1;

        //                 rst av ad       al bv bd        bl rdy  ar br sel ov od        ol os ca cb
        vecs[0]  = mk(1, 0, 0,        0, 0, 0,        0, 1,   0, 0, 0,  0, 0,        0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0,        0, 0, 0,        0, 1,   0, 0, 0,  0, 0,        0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0,        0, 0, 0,        0, 1,   0, 0, 0,  0, 0,        0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 'hdecaf,  1, 0, 0,        0, 1,   1, 0, 0,  1, 'hdecaf,  1, 0, 1, 0);
        vecs[4]  = mk(0, 1, 'hcafe,   1, 1, 'hface,   1, 1,   0, 1, 1,  1, 'hface,   1, 1, 1, 1);
        vecs[5]  = mk(0, 1, 'hcafe,   1, 1, 'hface,   1, 1,   1, 0, 0,  1, 'hcafe,   1, 0, 2, 1);
        vecs[6]  = mk(0, 1, 'hcafe,   1, 1, 'hface,   1, 1,   0, 1, 1,  1, 'hface,   1, 1, 2, 2);
        vecs[7]  = mk(0, 0, 0,        0, 0, 0,        0, 1,   0, 0, 1,  0, 'hface,   1, 1, 2, 2);
        vecs[8]  = mk(0, 1, 'h11,     1, 0, 0,        0, 1,   1, 0, 0,  1, 'h11,     1, 0, 3, 2);
        vecs[9]  = mk(0, 1, 'h77,     1, 1, 'h32,     0, 1,   0, 1, 1,  1, 'h32,     0, 1, 3, 2);
        vecs[10] = mk(0, 1, 'h77,     1, 1, 'h31,     0, 1,   0, 1, 1,  1, 'h31,     0, 1, 3, 2);
        vecs[11] = mk(0, 1, 'h77,     1, 1, 'h30,     1, 1,   0, 1, 1,  1, 'h30,     1, 1, 3, 3);
        vecs[12] = mk(0, 1, 'h77,     1, 0, 0,        0, 1,   1, 0, 0,  1, 'h77,     1, 0, 4, 3);
        vecs[13] = mk(0, 0, 0,        0, 1, 'hfaced,  1, 1,   0, 1, 1,  1, 'hfaced,  1, 1, 4, 4);
        for (int i = 14; i <= 18; i++)
            vecs[i] = mk(0, 1, 'haa,  1, 1, 'hbb,     1, 0,   0, 0, 0,  1, 'hfaced,  1, 1, 4, 4);
        vecs[19] = mk(0, 1, 'haa,     1, 1, 'hbb,     1, 1,   1, 0, 0,  1, 'haa,     1, 0, 5, 4);
        vecs[20] = mk(0, 1, 'haa,     1, 1, 'hbb,     1, 1,   0, 1, 1,  1, 'hbb,     1, 1, 5, 5);
        vecs[21] = mk(0, 0, 0,        0, 0, 0,        0, 1,   0, 0, 1,  0, 'hbb,     1, 1, 5, 5);
        vecs[22] = mk(0, 1, 'h5a,     1, 0, 0,        0, 1,   1, 0, 0,  1, 'h5a,     1, 0, 6, 5);
        vecs[23] = mk(0, 1, 'ha1,     0, 0, 0,        0, 1,   1, 0, 0,  1, 'ha1,     0, 0, 6, 5);
        vecs[24] = mk(1, 1, 'ha2,     0, 1, 'hb1,     1, 1,   0, 0, 0,  0, 0,        0, 0, 0, 0);
        vecs[25] = mk(0, 0, 0,        0, 1, 'hb2,     1, 1,   0, 1, 1,  1, 'hb2,     1, 1, 0, 1);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].ad, vecs[i].al,
                  vecs[i].bv, vecs[i].bd, vecs[i].bl, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d a_ready", i), 128'(a_ready), 128'(vecs[i].ear));
            chk($sformatf("v%0d b_ready", i), 128'(b_ready), 128'(vecs[i].ebr));
            chk($sformatf("v%0d sel", i),     128'(sel),     128'(vecs[i].esel));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(vecs[i].eov));
            chk($sformatf("v%0d out_data", i),  128'(out_data),  128'(vecs[i].eod));
            chk($sformatf("v%0d out_last", i),  128'(out_last),  128'(vecs[i].eol));
            chk($sformatf("v%0d out_src", i),   128'(out_src),   128'(vecs[i].eos));
            chk($sformatf("v%0d pkt_cnt_a", i), 128'(pkt_cnt_a), 128'(vecs[i].eca));
            chk($sformatf("v%0d pkt_cnt_b", i), 128'(pkt_cnt_b), 128'(vecs[i].ecb));
            $display("vec %0d: ar=%0b br=%0b sel=%0b ov=%0b od=%h src=%0b cnt=%0d/%0d",
                     i, vecs[i].ear, vecs[i].ebr, vecs[i].esel, out_valid, out_data,
                     out_src, pkt_cnt_a, pkt_cnt_b);
        end

        // Alternation from reset with both requesters sending single beats.
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 'hcafe, 1, 1, 'hface, 1, 1);
            #1;
            chk($sformatf("alt%0d sel", k),     128'(sel),     128'(k % 2));
            chk($sformatf("alt%0d a_ready", k), 128'(a_ready), 128'((k + 1) % 2));
            chk($sformatf("alt%0d b_ready", k), 128'(b_ready), 128'(k % 2));
            @(posedge clk);
            #1;
            chk($sformatf("alt%0d out_data", k), 128'(out_data),
                (k % 2 == 1) ? 128'hface : 128'hcafe);
            $display("alt %0d: sel=%0b src=%0b data=%h", k, sel, out_src, out_data);
        end
        chk("alt pkt_cnt_a", 128'(pkt_cnt_a), 128'd4);
        chk("alt pkt_cnt_b", 128'(pkt_cnt_b), 128'd4);

        // Reset inside an A lock while prio points at B: both must be discarded.
        drive(0, 1, 'h1, 1, 0, 0, 0, 1);
        drive(0, 1, 'h2, 0, 0, 0, 0, 1);
        drive(1, 1, 'h3, 0, 0, 0, 0, 1);
        drive(0, 1, 'h4, 1, 1, 'h5, 1, 1);
        #1;
        chk("rstlock a_ready", 128'(a_ready), 128'd1);
        chk("rstlock b_ready", 128'(b_ready), 128'd0);
        @(posedge clk);
        #1;
        chk("rstlock out_data", 128'(out_data), 128'h4);
        chk("rstlock pkt_cnt_a", 128'(pkt_cnt_a), 128'd1);
        $display("rstlock: data=%h cnt_a=%0d", out_data, pkt_cnt_a);

        // Counter wrap on A-only single-beat packets.
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 'h9, 1, 0, 0, 0, 1);
        repeat (65534) @(posedge clk);
        @(posedge clk);
        #1;
        chk("wrap pre pkt_cnt_a", 128'(pkt_cnt_a), 128'hffff);
        @(posedge clk);
        #1;
        chk("wrap pkt_cnt_a", 128'(pkt_cnt_a), 128'd0);
        chk("wrap pkt_cnt_b", 128'(pkt_cnt_b), 128'd0);
        chk("wrap out_valid", 128'(out_valid), 128'd1);
        $display("wrap: cnt_a=%0d cnt_b=%0d", pkt_cnt_a, pkt_cnt_b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
